// File: rtl/nrzi_to_nrz.sv
// rtl/nrzi_to_nrz.sv - NRZI line decoder with sync hunt, stuffed-bit removal and LSB-first byte assembly (option macro: NRZI_DESTUFF_EN)
module nrzi_to_nrz #(
  parameter logic       IDLE_LEVEL   = 1'b0,
  parameter logic [7:0] SYNC_PATTERN = 8'b0000_0001,
  parameter int         STUFF_RUN    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       In,
  input  logic       in_valid,
  output logic       Out,
  output logic       out_bit_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       sof,
  output logic       eop,
  output logic       err
);

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  state_t     state;
  logic       prev_level;
  // Only the 7 most recent bits are stored; the incoming bit completes the 8-bit window.
  logic [6:0] sync_sr;
  // Partial byte: new bits enter at the top so the first bit ends up at bit 0.
  logic [6:0] byte_sr;
  logic [2:0] bit_cnt;
  logic       dbit;
  logic [7:0] sync_next;

  assign dbit      = In ^ prev_level;
  assign sync_next = {sync_sr, dbit};

`ifdef NRZI_DESTUFF_EN
  localparam int OW = $clog2(STUFF_RUN + 1);
  logic [OW-1:0] ones_cnt;
  logic          stuff_slot;

  // The next bit after a full run of ones is the stuffed position.
  assign stuff_slot = (ones_cnt == OW'(STUFF_RUN));
`else
  logic unused_stuff_run;
  assign unused_stuff_run = (STUFF_RUN != 0);
`endif

  // Decoder, sync hunter, destuffer and byte assembler with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= HUNT;
      prev_level    <= IDLE_LEVEL;
      sync_sr       <= '0;
      byte_sr       <= '0;
      bit_cnt       <= '0;
      Out           <= 1'b0;
      out_bit_valid <= 1'b0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      sof           <= 1'b0;
      eop           <= 1'b0;
      err           <= 1'b0;
`ifdef NRZI_DESTUFF_EN
      ones_cnt      <= '0;
`endif
    end else begin
      out_valid     <= 1'b0;
      sof           <= 1'b0;
      eop           <= 1'b0;
      err           <= 1'b0;
      out_bit_valid <= in_valid;
      if (in_valid) begin
        Out        <= dbit;
        prev_level <= In;
      end

      case (state)
        HUNT: begin
          if (in_valid) begin
            sync_sr <= sync_next[6:0];
            if (sync_next == SYNC_PATTERN) begin
              sof     <= 1'b1;
              state   <= DATA;
              bit_cnt <= '0;
`ifdef NRZI_DESTUFF_EN
              ones_cnt <= '0;
`endif
            end
          end
        end

        DATA: begin
          if (!in_valid) begin
            // Line qualifier dropped: packet over; a partial byte is an error.
            eop     <= 1'b1;
            err     <= (bit_cnt != 3'd0);
            state   <= HUNT;
            sync_sr <= '0;
            bit_cnt <= '0;
`ifdef NRZI_DESTUFF_EN
            ones_cnt <= '0;
`endif
          end
`ifdef NRZI_DESTUFF_EN
          else if (stuff_slot) begin
            if (!dbit) begin
              ones_cnt <= '0;
            end else begin
              // A one where a stuffed zero was due: abandon the packet silently.
              err      <= 1'b1;
              state    <= HUNT;
              sync_sr  <= '0;
              bit_cnt  <= '0;
              ones_cnt <= '0;
            end
          end
`endif
          else begin
            byte_sr <= {dbit, byte_sr[6:1]};
`ifdef NRZI_DESTUFF_EN
            ones_cnt <= dbit ? ones_cnt + OW'(1) : '0;
`endif
            if (bit_cnt == 3'd7) begin
              out_data  <= {dbit, byte_sr};
              out_valid <= 1'b1;
              bit_cnt   <= '0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_nrzi_to_nrz.sv
// tb/tb_nrzi_to_nrz.sv - self-checking bench for nrzi_to_nrz: vector table, directed sequences, randomized model check
module tb_nrzi_to_nrz;

  localparam logic [7:0] SYNC      = 8'b0000_0001;
  localparam int         STUFF_RUN = 6;
`ifdef NRZI_DESTUFF_EN
  localparam bit DESTUFF = 1'b1;
`else
  localparam bit DESTUFF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, In, in_valid;
  logic       Out, out_bit_valid, out_valid, sof, eop, err;
  logic [7:0] out_data;

  nrzi_to_nrz dut (
    .clk(clk), .reset(reset), .In(In), .in_valid(in_valid),
    .Out(Out), .out_bit_valid(out_bit_valid), .out_data(out_data),
    .out_valid(out_valid), .sof(sof), .eop(eop), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       d;
    logic       v;
    logic       sof;
    logic       ov;
    logic [7:0] data;
    logic       eop;
    logic       err;
  } row_t;

  int n_checks = 0;
  int n_errors = 0;
  logic lvl = 1'b0;

  bit m_hunt;
  bit q_hist[$];
  bit q_bits[$];
  int m_ones;
  logic [7:0] m_data;
  logic e_obv, e_out, e_ov, e_sof, e_eop, e_err;
  logic [7:0] e_data;

  int c_sof, c_ov, c_eop, c_err, c_obv, c_eop_err;
  logic [7:0] c_last;

  row_t tbl[17];
  logic [7:0] b_a5 = 8'hA5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic row_t mk(input logic d, input logic v, input logic s, input logic ov,
                              input logic [7:0] data, input logic e, input logic er);
    row_t r;
    r.d = d; r.v = v; r.sof = s; r.ov = ov; r.data = data; r.eop = e; r.err = er;
    return r;
  endfunction

  function automatic void go_hunt();
    m_hunt = 1'b1;
    q_hist.delete();
    q_bits.delete();
    m_ones = 0;
  endfunction

  // Reference: works on the decoded bit stream with queues, producing next-cycle outputs.
  function automatic void model_step(input bit r, input bit d, input bit v);
    int unsigned win;
    e_ov = 0; e_sof = 0; e_eop = 0; e_err = 0;
    if (r) begin
      go_hunt();
      m_data = 8'h00;
      e_obv = 0; e_out = 0; e_data = 8'h00;
      return;
    end
    e_obv = v; e_out = d;
    if (m_hunt) begin
      if (v) begin
        q_hist.push_back(d);
        if (q_hist.size() > 8) void'(q_hist.pop_front());
        win = 0;
        foreach (q_hist[i]) win = (win << 1) | 32'(q_hist[i]);
        if (win == 32'(SYNC)) begin
          e_sof = 1;
          m_hunt = 0;
          q_bits.delete();
          m_ones = 0;
        end
      end
    end else if (!v) begin
      e_eop = 1;
      e_err = (q_bits.size() != 0);
      go_hunt();
    end else if (DESTUFF && m_ones == STUFF_RUN) begin
      if (d) begin
        e_err = 1;
        go_hunt();
      end else begin
        m_ones = 0;
      end
    end else begin
      q_bits.push_back(d);
      m_ones = d ? m_ones + 1 : 0;
      if (q_bits.size() == 8) begin
        m_data = 8'h00;
        foreach (q_bits[i]) m_data = m_data | (8'(q_bits[i]) << i);
        e_ov = 1;
        q_bits.delete();
      end
    end
    e_data = m_data;
  endfunction

  task automatic clear_counts();
    c_sof = 0; c_ov = 0; c_eop = 0; c_err = 0; c_obv = 0; c_eop_err = 0; c_last = 8'h00;
  endtask

  // One clock: encode the decoded bit onto the line, step, sample on the falling edge.
  task automatic cycle(input bit r, input bit d, input bit v, input bit use_model);
    reset = r;
    in_valid = v;
    if (!r && v) begin
      lvl = lvl ^ d;
      In = lvl;
    end else begin
      In = 1'($urandom_range(0, 1));
    end
    if (use_model) model_step(r, d, v);
    @(posedge clk);
    @(negedge clk);
    if (r) lvl = 1'b0;
    if (sof) c_sof++;
    if (out_valid) begin c_ov++; c_last = out_data; end
    if (eop) c_eop++;
    if (err) c_err++;
    if (out_bit_valid) c_obv++;
    if (eop && err) c_eop_err++;
    if (use_model) begin
      chk("m_obv", out_bit_valid, e_obv);
      if (e_obv) chk("m_out", Out, e_out);
      chk("m_sof", sof, e_sof);
      chk("m_ov", out_valid, e_ov);
      chk("m_data", out_data, e_data);
      chk("m_eop", eop, e_eop);
      chk("m_err", err, e_err);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1);
    clear_counts();
  endtask

  task automatic send_sync();
    for (int i = 7; i >= 0; i--) cycle(1'b0, SYNC[i], 1'b1, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) cycle(1'b0, b[i], 1'b1, 1'b1);
  endtask

  task automatic send_bits(input logic [15:0] b, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, b[i], 1'b1, 1'b1);
  endtask

  initial begin
    reset = 1'b1; In = 1'b0; in_valid = 1'b1;

    // Reset with random line, all outputs zero.
    do_reset(2);
    chk("rst_out", {Out, out_bit_valid, out_valid, sof, eop, err}, 6'b0);
    chk("rst_data", out_data, 8'h00);

    // Vector table: sync, 0xA5, end of packet.
    for (int i = 0; i < 7; i++) tbl[i] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tbl[7] = mk(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 8; i < 16; i++)
      tbl[i] = mk(b_a5[i-8], 1'b1, 1'b0, i == 15, (i == 15) ? 8'hA5 : 8'h00, 1'b0, 1'b0);
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) begin
      cycle(1'b0, tbl[i].d, tbl[i].v, 1'b0);
      chk("tbl_obv", out_bit_valid, tbl[i].v);
      if (tbl[i].v) chk("tbl_out", Out, tbl[i].d);
      chk("tbl_sof", sof, tbl[i].sof);
      chk("tbl_ov", out_valid, tbl[i].ov);
      chk("tbl_data", out_data, tbl[i].data);
      chk("tbl_eop", eop, tbl[i].eop);
      chk("tbl_err", err, tbl[i].err);
    end

    // Six ones, stuffed zero, two ones.
    do_reset(2);
    send_sync();
    clear_counts();
    send_bits(16'b1_1011_1111, 9);
    chk("t3_obv", c_obv, 9);
    chk("t3_ov", c_ov, 1);
    chk("t3_data", c_last, DESTUFF ? 8'hFF : 8'hBF);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_eop", c_eop, 1);
    chk("t3_err", c_err, DESTUFF ? 0 : 1);

    // Seven ones after sync, then a fresh sync.
    do_reset(2);
    send_sync();
    send_bits(16'h007F, 7);
    chk("t4_err7", c_err, DESTUFF ? 1 : 0);
    chk("t4_ov7", c_ov, 0);
    chk("t4_eop7", c_eop, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_eop", c_eop, DESTUFF ? 0 : 1);
    chk("t4_err", c_err, 1);
    clear_counts();
    send_sync();
    send_byte(8'h3C);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_resof", c_sof, 1);
    chk("t4_reov", c_ov, 1);
    chk("t4_redata", c_last, 8'h3C);
    chk("t4_reeop", c_eop, 1);
    chk("t4_reerr", c_err, 0);

    // Twelve data bits then end: one byte, eop with err.
    do_reset(2);
    send_sync();
    send_byte(8'h5A);
    send_bits(16'b1001, 4);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5a_ov", c_ov, 1);
    chk("t5a_data", c_last, 8'h5A);
    chk("t5a_eoperr", c_eop_err, 1);

    // Sixteen data bits: two bytes, clean eop.
    do_reset(2);
    send_sync();
    send_byte(8'h5A);
    send_byte(8'hC3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5b_ov", c_ov, 2);
    chk("t5b_data", c_last, 8'hC3);
    chk("t5b_eop", c_eop, 1);
    chk("t5b_err", c_err, 0);

    // Reset mid-byte, then zeros must not produce anything.
    do_reset(2);
    send_sync();
    send_bits(16'b0101, 4);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    chk("t6_rst", {Out, out_bit_valid, out_valid, sof, eop, err}, 6'b0);
    clear_counts();
    send_bits(16'h0000, 10);
    chk("t6_ov0", c_ov, 0);
    chk("t6_sof0", c_sof, 0);
    send_sync();
    send_byte(8'hA5);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_sof", c_sof, 1);
    chk("t6_ov", c_ov, 1);
    chk("t6_data", c_last, 8'hA5);

    // Randomized packets against the reference model.
    do_reset(1);
    for (int p = 0; p < 60; p++) begin
      int run;
      int n;
      bit d;
      if ($urandom_range(0, 9) == 0) cycle(1'b1, 1'b0, 1'b1, 1'b1);
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++)
        cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b1);
      send_sync();
      run = 0;
      n = $urandom_range(0, 40);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 99) == 0) cycle(1'b1, 1'b0, 1'b1, 1'b1);
        if (DESTUFF && run == STUFF_RUN && $urandom_range(0, 9) != 0) d = 1'b0;
        else d = ($urandom_range(0, 9) < 7);
        run = d ? run + 1 : 0;
        cycle(1'b0, d, 1'b1, 1'b1);
      end
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
